// File: rtl/multicycle_sequencer.sv
// Multicycle CPU control sequencer: FETCH/DECODE/EXEC/MEM/WB FSM driving datapath enables,
// with a memory-busy interlock that overrides stall and a retired-instruction counter.
module multicycle_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  opcode,
  input  logic        alu_zero,
  input  logic        mem_ready,
  input  logic        stall,
  output logic        ir_w,
  output logic        pc_w,
  output logic        iord,
  output logic        mem_req,
  output logic        mem_we,
  output logic        reg_w,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [2:0]  state,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  state_e      state_q, state_d, state_nxt;
  logic [15:0] retired_q, retired_d;
  logic        busy_q, busy_d;
  logic        run_q;
  logic        hold, advance, retire;
  logic        is_lw, is_sw, is_beq, is_bne, is_j, is_br, is_mem;

  assign is_lw  = (opcode == 4'd0);
  assign is_sw  = (opcode == 4'd1);
  assign is_beq = (opcode == 4'd11);
  assign is_bne = (opcode == 4'd12);
  assign is_j   = (opcode == 4'd13);
  assign is_br  = is_beq | is_bne;
  assign is_mem = is_lw | is_sw;

  // An outstanding memory transaction cannot be paused, so busy masks stall.
  assign hold    = stall & ~busy_q;
  // run_q keeps every output low until the first clock edge after reset release.
  assign advance = run_q & ~hold;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      retired_q <= 16'd0;
      busy_q    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      busy_q    <= busy_d;
      run_q     <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = StFetch;
    retire    = 1'b0;
    case (state_q)
      StFetch:  state_nxt = mem_ready ? StDecode : StFetch;
      StDecode: begin
        if (is_j) begin
          state_nxt = StFetch;
          retire    = 1'b1;
        end else begin
          state_nxt = StExec;
        end
      end
      StExec: begin
        if (is_mem) begin
          state_nxt = StMem;
        end else if (is_br) begin
          state_nxt = StFetch;
          retire    = 1'b1;
        end else begin
          state_nxt = StWb;
        end
      end
      StMem: begin
        if (!mem_ready) begin
          state_nxt = StMem;
        end else if (is_sw) begin
          state_nxt = StFetch;
          retire    = 1'b1;
        end else begin
          state_nxt = StWb;
        end
      end
      StWb: begin
        state_nxt = StFetch;
        retire    = 1'b1;
      end
      default: state_nxt = StFetch;
    endcase
    state_d   = advance ? state_nxt : state_q;
    retired_d = retired_q + {15'd0, advance & retire};
    // mem_ready with no request outstanding is ignored.
    busy_d    = mem_req ? ~mem_ready : busy_q;
  end

  // Output logic
  always_comb begin
    ir_w       = 1'b0;
    pc_w       = 1'b0;
    iord       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    reg_w      = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    pc_src     = 2'd0;
    alu_src_b  = 2'd0;
    alu_op     = 2'b00;
    if (run_q) begin
      case (state_q)
        StFetch: begin
          mem_req   = 1'b1;
          alu_src_b = 2'd1;
          ir_w      = mem_ready;
          pc_w      = mem_ready;
        end
        StDecode: begin
          alu_src_b = 2'd2;
          if (is_j) begin
            pc_w   = 1'b1;
            pc_src = 2'd2;
          end
        end
        StExec: begin
          alu_src_a = 1'b1;
          if (is_mem) begin
            alu_src_b = 2'd2;
          end else if (is_br) begin
            alu_op = 2'b01;
            pc_src = 2'd1;
            pc_w   = is_beq ? alu_zero : ~alu_zero;
          end else begin
            alu_op = 2'b10;
          end
        end
        StMem: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = is_sw;
        end
        StWb: begin
          reg_w = 1'b1;
          if (is_lw) begin
            mem_to_reg = 1'b1;
          end else begin
            reg_dst = 1'b1;
          end
        end
        default: ;
      endcase
      if (hold) begin
        ir_w    = 1'b0;
        pc_w    = 1'b0;
        reg_w   = 1'b0;
        mem_we  = 1'b0;
        mem_req = 1'b0;
      end
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed instruction sequences with literal expectations,
// then randomized traffic checked every cycle against a per-opcode step-sequence model.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        stall = 1'b0;
  logic        ir_w, pc_w, iord, mem_req, mem_we, reg_w, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic [2:0]  state;
  logic [15:0] retired;

  int vectors = 0;
  int miscompares = 0;

  multicycle_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .alu_zero   (alu_zero),
    .mem_ready  (mem_ready),
    .stall      (stall),
    .ir_w       (ir_w),
    .pc_w       (pc_w),
    .iord       (iord),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .reg_w      (reg_w),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .pc_src     (pc_src),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .state      (state),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  // Each instruction class is a fixed list of visited states; m_pos indexes into it.
  function automatic int seq_len(input logic [3:0] op);
    case (op)
      4'd0:         return 5;
      4'd1:         return 4;
      4'd11, 4'd12: return 3;
      4'd13:        return 2;
      default:      return 4;
    endcase
  endfunction

  function automatic logic [2:0] seq_st(input logic [3:0] op, input int pos);
    bit is_dp;
    is_dp = !(op == 4'd0 || op == 4'd1 || op == 4'd11 || op == 4'd12 || op == 4'd13);
    if (is_dp && pos == 3) return 3'd4;
    return pos[2:0];
  endfunction

  // {ir_w,pc_w,iord,mem_req,mem_we,reg_w,reg_dst,mem_to_reg,alu_src_a,pc_src,alu_src_b,alu_op}
  function automatic logic [14:0] exp_ctrl(input logic [3:0] op, input logic [2:0] st,
                                           input logic run, input logic busy, input logic stl,
                                           input logic rdy, input logic z);
    logic irw, pcw, io, mrq, mwe, rw, rd, m2r, a;
    logic [1:0] ps, b, aop;
    logic se;
    {irw, pcw, io, mrq, mwe, rw, rd, m2r, a} = '0;
    ps = 2'd0; b = 2'd0; aop = 2'd0;
    se = stl & ~busy;
    if (run) begin
      if (st == 3'd0) begin
        mrq = 1'b1; b = 2'd1; irw = rdy; pcw = rdy;
      end else if (st == 3'd1) begin
        b = 2'd2;
        if (op == 4'd13) begin pcw = 1'b1; ps = 2'd2; end
      end else if (st == 3'd2) begin
        a = 1'b1;
        if (op <= 4'd1) b = 2'd2;
        else if (op == 4'd11 || op == 4'd12) begin
          aop = 2'b01; ps = 2'd1; pcw = (op == 4'd11) ? z : ~z;
        end else aop = 2'b10;
      end else if (st == 3'd3) begin
        mrq = 1'b1; io = 1'b1; mwe = (op == 4'd1);
      end else if (st == 3'd4) begin
        rw = 1'b1; m2r = (op == 4'd0); rd = (op != 4'd0);
      end
      if (se) {irw, pcw, rw, mwe, mrq} = '0;
    end
    return {irw, pcw, io, mrq, mwe, rw, rd, m2r, a, ps, b, aop};
  endfunction

  int          m_pos = 0;
  logic [15:0] m_ret = 16'd0;
  logic        m_busy = 1'b0;
  logic        m_run = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    logic [2:0] st;
    logic       mem_ph, se;
    int         np;
    if (!rst_n) begin
      m_pos <= 0; m_ret <= 16'd0; m_busy <= 1'b0; m_run <= 1'b0;
    end else if (!m_run) begin
      m_run <= 1'b1;
    end else begin
      st     = seq_st(opcode, m_pos);
      mem_ph = (st == 3'd0) || (st == 3'd3);
      se     = stall & ~m_busy;
      if (mem_ph && !se) m_busy <= ~mem_ready;
      if (!se && (!mem_ph || mem_ready)) begin
        np = m_pos + 1;
        if (np == seq_len(opcode)) begin
          m_pos <= 0;
          m_ret <= m_ret + 16'd1;
        end else begin
          m_pos <= np;
        end
      end
    end
  end

  // Every-cycle compare against the model, away from the rising edge.
  always @(negedge clk) begin : compare
    logic [14:0] ectl, actl;
    logic [2:0]  est;
    #2;
    est  = m_run ? seq_st(opcode, m_pos) : 3'd0;
    ectl = exp_ctrl(opcode, est, m_run, m_busy, stall, mem_ready, alu_zero);
    actl = {ir_w, pc_w, iord, mem_req, mem_we, reg_w, reg_dst, mem_to_reg, alu_src_a,
            pc_src, alu_src_b, alu_op};
    vectors += 3;
    if (actl !== ectl) begin
      miscompares++;
      $display("FAIL ctrl @%0t: got %b want %b", $time, actl, ectl);
    end
    if (state !== est) begin
      miscompares++;
      $display("FAIL state @%0t: got %0d want %0d", $time, state, est);
    end
    if (retired !== m_ret) begin
      miscompares++;
      $display("FAIL retired @%0t: got %h want %h", $time, retired, m_ret);
    end
  end

  task automatic drive(input logic [3:0] op, input logic s, input logic r, input logic z);
    @(negedge clk);
    opcode = op; stall = s; mem_ready = r; alu_zero = z;
    #2;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  initial begin
    logic rdy_pat [8];
    int   irc, pcc;
    rdy_pat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    drive(4'd2, 1'b0, 1'b1, 1'b0);
    lit("rst_state", state, 0); lit("rst_mem_req", mem_req, 0); lit("rst_retired", retired, 0);
    #1 rst_n = 1'b1;

    // DP: 0,1,2,4 then retire
    drive(4'd2, 1'b0, 1'b1, 1'b0); lit("dp_fetch", state, 0); lit("dp_first_req", mem_req, 1);
    drive(4'd2, 1'b0, 1'b1, 1'b0); lit("dp_decode", state, 1);
    drive(4'd2, 1'b0, 1'b1, 1'b0); lit("dp_exec", state, 2);
    drive(4'd2, 1'b0, 1'b1, 1'b0); lit("dp_wb", state, 4);
    lit("dp_reg_w", reg_w, 1); lit("dp_reg_dst", reg_dst, 1);

    // LW with two FETCH waits and one MEM wait: 8 cycles
    irc = 0; pcc = 0;
    for (int i = 0; i < 8; i++) begin
      drive(4'd0, 1'b0, rdy_pat[i], 1'b0);
      irc += int'(ir_w); pcc += int'(pc_w);
      if (i == 0) lit("dp_retired", retired, 1);
      if (i == 7) begin lit("lw_wb", state, 4); lit("lw_mem_to_reg", mem_to_reg, 1); end
    end
    lit("lw_ir_w_pulses", irc, 1); lit("lw_pc_w_pulses", pcc, 1);

    drive(4'd11, 1'b0, 1'b1, 1'b1); lit("lw_retired", retired, 2);
    drive(4'd11, 1'b0, 1'b1, 1'b1);
    drive(4'd11, 1'b0, 1'b1, 1'b1); lit("beq_pc_w", pc_w, 1); lit("beq_pc_src", pc_src, 1);
    drive(4'd12, 1'b0, 1'b1, 1'b1); lit("beq_retired", retired, 3); lit("beq_back", state, 0);
    drive(4'd12, 1'b0, 1'b1, 1'b1);
    drive(4'd12, 1'b0, 1'b1, 1'b1); lit("bne_pc_w", pc_w, 0); lit("bne_exec", state, 2);
    drive(4'd13, 1'b0, 1'b1, 1'b0); lit("bne_retired", retired, 4);
    drive(4'd13, 1'b0, 1'b1, 1'b0); lit("j_pc_w", pc_w, 1); lit("j_pc_src", pc_src, 2);

    // Stall in EXEC for three cycles
    drive(4'd2, 1'b0, 1'b1, 1'b0); lit("j_retired", retired, 5); lit("j_back", state, 0);
    drive(4'd2, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(4'd2, 1'b1, 1'b1, 1'b0);
      lit("stall_state", state, 2);
      lit("stall_enables", {ir_w, pc_w, reg_w, mem_we, mem_req}, 0);
    end
    drive(4'd2, 1'b0, 1'b1, 1'b0);
    drive(4'd2, 1'b0, 1'b1, 1'b0);

    // Stall ignored while SW transaction is outstanding
    drive(4'd1, 1'b0, 1'b1, 1'b0); lit("stall_dp_retired", retired, 6);
    drive(4'd1, 1'b0, 1'b1, 1'b0);
    drive(4'd1, 1'b0, 1'b1, 1'b0);
    drive(4'd1, 1'b0, 1'b0, 1'b0);
    drive(4'd1, 1'b1, 1'b0, 1'b0);
    lit("busy_state", state, 3); lit("busy_mem_req", mem_req, 1); lit("busy_mem_we", mem_we, 1);
    drive(4'd1, 1'b1, 1'b1, 1'b0); lit("busy_complete_req", mem_req, 1);

    // Counter wrap: preload 0xFFFF while idle-stalled in FETCH
    drive(4'd13, 1'b1, 1'b0, 1'b0);
    lit("sw_retired", retired, 7); lit("idle_stall_req", mem_req, 0);
    #1;
    force dut.retired_q = 16'hffff;
    m_ret = 16'hffff;
    #1;
    release dut.retired_q;
    drive(4'd13, 1'b0, 1'b1, 1'b0); lit("preload", retired, 16'hffff);
    drive(4'd13, 1'b0, 1'b1, 1'b0);
    drive(4'd13, 1'b1, 1'b0, 1'b0); lit("wrap", retired, 0);

    // Asynchronous reset in the middle of MEM
    drive(4'd0, 1'b0, 1'b1, 1'b0);
    drive(4'd0, 1'b0, 1'b1, 1'b0);
    drive(4'd0, 1'b0, 1'b1, 1'b0);
    drive(4'd0, 1'b0, 1'b0, 1'b0); lit("pre_rst_mem", state, 3); lit("pre_rst_req", mem_req, 1);
    #1 rst_n = 1'b0;
    #1 lit("async_rst_req", mem_req, 0); lit("async_rst_state", state, 0);
    drive(4'd0, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;

    // Randomized traffic; opcode only changes while the model sits in FETCH
    for (int i = 0; i < 4000; i++) begin
      drive((m_pos == 0) ? 4'($urandom_range(0, 15)) : opcode,
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) != 0), 1'($urandom));
      #1 rst_n = ($urandom_range(0, 399) != 0);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
